// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation modes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of up to STEP bit positions in the requested mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIST_W = 6
) (
  input  logic [WIDTH-1:0]  i_word,
  input  logic [DIST_W-1:0] i_dist,
  input  shift_mode_e       i_mode,
  output logic [WIDTH-1:0]  o_word
);

  logic [WIDTH-1:0] w_rot;

  // Rotating right is a logical shift of the word concatenated with itself.
  assign w_rot = WIDTH'({i_word, i_word} >> i_dist);

  always_comb begin
    o_word = i_word;
    case (i_mode)
      MODE_SLL: o_word = i_word << i_dist;
      MODE_SRL: o_word = i_word >> i_dist;
      MODE_SRA: o_word = $signed(i_word) >>> i_dist;
      default:  o_word = w_rot;
    endcase
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter: applies at most STEP positions per clock until the
// requested amount is consumed, then pulses Done_OUT with the registered result.
module shift_unit_iter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start_IN,
  input  logic [WIDTH-1:0]   Data_IN,
  input  logic [SHAMT_W-1:0] Shamt_IN,
  input  logic [1:0]         Mode_IN,
  output logic               Ready_OUT,
  output logic               Busy_OUT,
  output logic               Done_OUT,
  output logic [WIDTH-1:0]   Result_OUT
);

  localparam int DIST_W = SHAMT_W + 1;
  localparam logic [DIST_W-1:0] STEP_C = DIST_W'(STEP);

  shift_state_e       r_state;
  shift_state_e       w_next;
  shift_mode_e        r_mode;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_result;
  logic [SHAMT_W-1:0] r_rem;
  logic [DIST_W-1:0]  w_dist;
  logic [WIDTH-1:0]   w_stepped;
  logic               w_last;

  assign w_last = {1'b0, r_rem} <= STEP_C;
  assign w_dist = w_last ? {1'b0, r_rem} : STEP_C;

  shift_step #(
    .WIDTH  (WIDTH),
    .DIST_W (DIST_W)
  ) u_step (
    .i_word (r_work),
    .i_dist (w_dist),
    .i_mode (r_mode),
    .o_word (w_stepped)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (Start_IN) w_next = (Shamt_IN != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // The result register only moves on the edge entering DONE, so it holds
  // the previous answer while a new request is still shifting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_work   <= '0;
      r_rem    <= '0;
      r_mode   <= MODE_SLL;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start_IN) begin
            r_work <= Data_IN;
            r_rem  <= Shamt_IN;
            r_mode <= shift_mode_e'(Mode_IN);
            if (Shamt_IN == '0) r_result <= Data_IN;
          end
        end
        ST_SHIFT: begin
          r_work <= w_stepped;
          r_rem  <= r_rem - w_dist[SHAMT_W-1:0];
          if (w_last) r_result <= w_stepped;
        end
        default: ;
      endcase
    end
  end

  // Reset masks the status outputs immediately, so an aborted run never pulses Done.
  assign Ready_OUT  = RST || (r_state == ST_IDLE);
  assign Busy_OUT   = !RST && ((r_state == ST_SHIFT) || (r_state == ST_DONE));
  assign Done_OUT   = !RST && (r_state == ST_DONE);
  assign Result_OUT = r_result;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Randomized and directed checks of shift_unit_iter against a one-shot
// arithmetic reference of each shift and its expected completion cycle.
module tb_shift_unit_iter;

  localparam int W       = 32;
  localparam int STEP    = 4;
  localparam int SHAMT_W = 5;

  logic               CLK = 1'b0;
  logic               RST;
  logic               Start_IN;
  logic [W-1:0]       Data_IN;
  logic [SHAMT_W-1:0] Shamt_IN;
  logic [1:0]         Mode_IN;
  logic               Ready_OUT;
  logic               Busy_OUT;
  logic               Done_OUT;
  logic [W-1:0]       Result_OUT;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] prevResult = '0;

  shift_unit_iter #(.WIDTH(W), .STEP(STEP), .SHAMT_W(SHAMT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start_IN   (Start_IN),
    .Data_IN    (Data_IN),
    .Shamt_IN   (Shamt_IN),
    .Mode_IN    (Mode_IN),
    .Ready_OUT  (Ready_OUT),
    .Busy_OUT   (Busy_OUT),
    .Done_OUT   (Done_OUT),
    .Result_OUT (Result_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Whole shift done in one go on a double-width word.
  function automatic logic [W-1:0] refShift(input logic [W-1:0] d, input int s, input logic [1:0] m);
    logic [2*W-1:0] t;
    case (m)
      2'd0: t = {{W{1'b0}}, d} << s;
      2'd1: t = {{W{1'b0}}, d} >> s;
      2'd2: t = {{W{d[W-1]}}, d} >> s;
      default: t = {d, d} >> s;
    endcase
    return t[W-1:0];
  endfunction

  task automatic applyStimulus(input logic [W-1:0] d, input int s, input logic [1:0] m, input bit poke);
    logic [W-1:0] exp;
    int n;
    int doneAt;
    int busyCnt;
    exp     = refShift(d, s, m);
    n       = (s + STEP - 1) / STEP;
    doneAt  = -1;
    busyCnt = 0;
    @(negedge CLK);
    Start_IN = 1'b1;
    Data_IN  = d;
    Shamt_IN = SHAMT_W'(s);
    Mode_IN  = m;
    checkOutput("readyAtStart", W'(Ready_OUT), W'(1));
    @(posedge CLK);
    #1;
    Start_IN = 1'b0;
    Data_IN  = $urandom;
    Shamt_IN = SHAMT_W'($urandom);
    Mode_IN  = 2'($urandom);
    for (int j = 0; j < 40 && doneAt < 0; j++) begin
      @(negedge CLK);
      if (j == 0 && n > 0) checkOutput("resultHeld", Result_OUT, prevResult);
      checkOutput("doneReadyExcl", W'(Done_OUT & Ready_OUT), '0);
      if (Busy_OUT) busyCnt++;
      if (Done_OUT) begin
        doneAt = j;
        checkOutput("result", Result_OUT, exp);
      end
      if (poke && j < n) begin
        Start_IN = 1'b1;
        Data_IN  = $urandom;
        Shamt_IN = SHAMT_W'($urandom);
        Mode_IN  = 2'($urandom);
      end else begin
        Start_IN = 1'b0;
      end
    end
    checkOutput("doneCycle", W'(doneAt), W'(n));
    checkOutput("busyCycles", W'(busyCnt), W'(n + 1));
    Start_IN = 1'b0;
    @(negedge CLK);
    checkOutput("backToIdle", W'(Ready_OUT), W'(1));
    checkOutput("noExtraDone", W'(Done_OUT), '0);
    checkOutput("resultKept", Result_OUT, exp);
    prevResult = exp;
  endtask

  initial begin
    RST      = 1'b1;
    Start_IN = 1'b0;
    Data_IN  = '0;
    Shamt_IN = '0;
    Mode_IN  = 2'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rstReady", W'(Ready_OUT), W'(1));
    checkOutput("rstBusy", W'(Busy_OUT), '0);
    checkOutput("rstDone", W'(Done_OUT), '0);
    checkOutput("rstResult", Result_OUT, '0);
    RST = 1'b0;

    applyStimulus(32'h0000_0001, 2, 2'd0, 1'b0);
    applyStimulus(32'h8000_0000, 31, 2'd2, 1'b0);
    applyStimulus(32'h8000_0000, 31, 2'd1, 1'b0);
    applyStimulus(32'h1234_5678, 8, 2'd3, 1'b0);
    for (int m = 0; m < 4; m++) applyStimulus(32'hDEAD_BEEF, 0, 2'(m), 1'b0);
    applyStimulus(32'hCAFE_F00D, 13, 2'd3, 1'b1);

    // Abort a 20-position SLL with reset on edge t0+3.
    @(negedge CLK);
    Start_IN = 1'b1;
    Data_IN  = 32'h0F0F_1234;
    Shamt_IN = SHAMT_W'(20);
    Mode_IN  = 2'd0;
    @(posedge CLK);
    #1;
    Start_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("inRstReady", W'(Ready_OUT), W'(1));
    checkOutput("inRstBusy", W'(Busy_OUT), '0);
    checkOutput("inRstDone", W'(Done_OUT), '0);
    @(negedge CLK);
    checkOutput("abortReady", W'(Ready_OUT), W'(1));
    checkOutput("abortResult", Result_OUT, '0);
    checkOutput("abortBusy", W'(Busy_OUT), '0);
    RST = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checkOutput("noDoneAfterAbort", W'(Done_OUT), '0);
    end
    prevResult = '0;

    for (int r = 0; r < 40; r++) begin
      applyStimulus($urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
